gs_ifetch: RTL and testbench

//   Instruction fetch front end; producer of the 32-bit instr word consumed by GS_Decoder.

---
 rtl/gs_ifetch.sv | 141 ++++++++++++++
 tb/tb_gs_ifetch.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gs_ifetch.sv
// Instruction fetch front end: issues in-order imem reads from the fetch PC, buffers returned
// words with their PC in a small FIFO, and flushes stale in-flight words on a redirect.
module gs_ifetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int unsigned CntW  = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned FCntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned FPtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned TPtrW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    typedef enum logic [1:0] {StBoot, StRun, StDrain} state_e;

    state_e            state_q;
    logic [31:0]       fetch_pc_q;
    logic [CntW-1:0]   inflight_q, inflight_d;
    logic [CntW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [31:0]       fifo_data_q [FIFO_DEPTH];
    logic [31:0]       fifo_pc_q   [FIFO_DEPTH];
    logic [FPtrW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [FCntW-1:0]  fifo_cnt_q;
    logic [31:0]       tag_q [MAX_INFLIGHT];
    logic [TPtrW-1:0]  tag_wr_q, tag_rd_q;

    logic [31:0] live;
    logic        credit, accept, rsp_fire, rsp_drop, push, pop;
    logic        unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    function automatic logic [TPtrW-1:0] tag_inc(input logic [TPtrW-1:0] p);
        return (p == TPtrW'(MAX_INFLIGHT - 1)) ? '0 : p + TPtrW'(1);
    endfunction

    always_comb begin
        // Stray responses with nothing outstanding are ignored rather than underflowing.
        rsp_fire = imem_rsp_valid && (inflight_q != '0);
        rsp_drop = rsp_fire && (drop_cnt_q != '0);
        live     = 32'(inflight_q) - 32'(drop_cnt_q) + 32'(fifo_cnt_q);
        credit   = (live < FIFO_DEPTH) && (32'(inflight_q) < MAX_INFLIGHT);

        imem_req_valid = (state_q != StBoot) && credit && !redirect_valid;
        imem_req_addr  = fetch_pc_q;
        accept         = imem_req_valid && imem_req_ready;

        instr_valid = (fifo_cnt_q != '0);
        instr       = fifo_data_q[rd_ptr_q];
        instr_pc    = fifo_pc_q[rd_ptr_q];

        push = rsp_fire && !rsp_drop && !redirect_valid;
        pop  = instr_valid && instr_ready && !redirect_valid;

        inflight_d = inflight_q + CntW'(accept) - CntW'(rsp_fire);
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            drop_cnt_d = inflight_q - CntW'(rsp_fire);
        end else if (rsp_drop) begin
            drop_cnt_d = drop_cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StBoot;
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else begin
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;

            if (redirect_valid) begin
                state_q <= (drop_cnt_d != '0) ? StDrain : StRun;
            end else begin
                unique case (state_q)
                    StBoot:  state_q <= StRun;
                    StRun:   state_q <= StRun;
                    StDrain: if (drop_cnt_d == '0) state_q <= StRun;
                    default: state_q <= StBoot;
                endcase
            end

            if (redirect_valid) begin
                fetch_pc_q <= {redirect_pc[31:2], 2'b00};
            end else if (accept) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end

            // The tag queue tracks every outstanding request, dropped ones included.
            if (accept)   tag_wr_q <= tag_inc(tag_wr_q);
            if (rsp_fire) tag_rd_q <= tag_inc(tag_rd_q);

            if (redirect_valid) begin
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
                fifo_cnt_q <= '0;
            end else begin
                if (push) begin
                    fifo_data_q[wr_ptr_q] <= imem_rsp_data;
                    fifo_pc_q[wr_ptr_q]   <= tag_q[tag_rd_q];
                    wr_ptr_q              <= wr_ptr_q + FPtrW'(1);
                end
                if (pop) rd_ptr_q <= rd_ptr_q + FPtrW'(1);
                fifo_cnt_q <= fifo_cnt_q + FCntW'(push) - FCntW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) tag_q[tag_wr_q] <= fetch_pc_q;
    end

    rsp_needs_inflight: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (inflight_q != '0));

endmodule

// File: tb/tb_gs_ifetch.sv
// Directed bench for gs_ifetch with a latency-configurable in-order memory model that can
// hold responses at or above a chosen address.
module tb_gs_ifetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    gs_ifetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mq[$];
    logic [31:0] req_log[$];
    logic [31:0] seen[$];
    int          cyc = 0;
    int          lat = 1;
    logic        hold_en = 1'b0;
    logic [31:0] hold_addr = 32'h8;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] seen_at(input int i);
        return (i < seen.size()) ? seen[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Memory: drives responses 2 time units after the edge, samples requests on the negedge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (rst) begin
                mq.delete();
                imem_rsp_valid = 1'b0;
            end else if (mq.size() > 0 && mq[0].due <= cyc &&
                         !(hold_en && mq[0].addr >= hold_addr)) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memf(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
            @(negedge clk);
            if (!rst && imem_req_valid && imem_req_ready) begin
                mq.push_back('{addr: imem_req_addr, due: cyc + lat});
                req_log.push_back(imem_req_addr);
            end
        end
    end

    // Consumer: records every accepted instruction and checks its data against its PC.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && instr_valid && instr_ready && !redirect_valid) begin
                seen.push_back(instr_pc);
                check("instr_data", instr, memf(instr_pc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1 rst = 1'b1;
        redirect_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        check({tag, "_req_addr"}, imem_req_addr, 32'h0);
        check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_drop_cnt"}, 32'(dut.drop_cnt_q), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        seen.delete();
        req_log.delete();
    endtask

    task automatic wait_reqs(input string tag, input int n);
        int k = 0;
        while (req_log.size() < n && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_reqs_reached"}, 32'(req_log.size() >= n), 32'd1);
    endtask

    initial begin
        int n0;
        int n1;
        int exp_drop;
        bit found;

        // Power-up reset and first-fetch timing.
        do_reset("rst0");
        check("rst0_instr", instr, 32'h0);
        check("rst0_instr_pc", instr_pc, 32'h0);
        @(negedge clk);
        check("boot_no_req", 32'(imem_req_valid), 32'd0);
        check("boot_no_instr", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        check("cyc2_no_instr", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("cyc3_instr_valid", 32'(instr_valid), 32'd1);
        check("cyc3_instr_pc", instr_pc, 32'h0);
        repeat (12) @(negedge clk);
        check("stream_len", 32'(seen.size() >= 5), 32'd1);
        for (int i = 0; i < seen.size(); i++) check("stream_pc", seen[i], 32'(4 * i));

        // Consumer stalled: credit caps outstanding work at the FIFO depth.
        instr_ready = 1'b0;
        do_reset("rst1");
        repeat (10) @(negedge clk);
        check("stall_req_count", 32'(req_log.size()), 32'd2);
        check("stall_req0", (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF, 32'h0);
        check("stall_req1", (req_log.size() > 1) ? req_log[1] : 32'hFFFF_FFFF, 32'h4);
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_instr_valid", 32'(instr_valid), 32'd1);
        @(posedge clk);
        #1 instr_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("release_len", 32'(seen.size() >= 3), 32'd1);
        for (int i = 0; i < seen.size(); i++) check("release_pc", seen[i], 32'(4 * i));

        // Redirect with 0x8 and 0xC held in flight: both must be dropped.
        hold_en = 1'b1;
        hold_addr = 32'h8;
        do_reset("rst2");
        wait_reqs("hold", 4);
        repeat (4) @(negedge clk);
        check("hold_no_credit", 32'(imem_req_valid), 32'd0);
        check("hold_seen_len", 32'(seen.size()), 32'd2);
        @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        n0 = seen.size();
        @(negedge clk);
        check("redir_no_req", 32'(imem_req_valid), 32'd0);
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        hold_en = 1'b0;
        @(negedge clk);
        check("redir_drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
        check("redir_req_valid", 32'(imem_req_valid), 32'd1);
        check("redir_req_addr", imem_req_addr, 32'h100);
        repeat (12) @(negedge clk);
        check("redir_len", 32'(seen.size() >= n0 + 3), 32'd1);
        for (int i = n0; i < seen.size(); i++) check("redir_pc", seen[i], 32'h100 + 32'(4 * (i - n0)));

        // Misaligned redirect target is truncated to a word boundary.
        @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        n1 = seen.size();
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        check("align_req_addr", imem_req_addr, 32'h200);
        repeat (8) @(negedge clk);
        check("align_pc0", seen_at(n1), 32'h200);
        check("align_pc1", seen_at(n1 + 1), 32'h204);

        // Redirect coinciding with a response and a pop.
        do_reset("rst3");
        found = 1'b0;
        exp_drop = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            #3;
            if (imem_rsp_valid && instr_valid && instr_ready) begin
                redirect_valid = 1'b1;
                redirect_pc = 32'h300;
                exp_drop = mq.size();
                found = 1'b1;
            end
        end
        check("coinc_found", 32'(found), 32'd1);
        n0 = seen.size();
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        check("coinc_instr_valid", 32'(instr_valid), 32'd0);
        check("coinc_drop_cnt", 32'(dut.drop_cnt_q), 32'(exp_drop));
        check("coinc_no_pop", 32'(seen.size()), 32'(n0));
        repeat (8) @(negedge clk);
        check("coinc_next_pc", seen_at(n0), 32'h300);

        // Reset while draining two stale words.
        hold_en = 1'b1;
        hold_addr = 32'h8;
        do_reset("rst4");
        wait_reqs("drain", 4);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_pc = 32'h500;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        check("drain_drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
        check("drain_instr_valid", 32'(instr_valid), 32'd0);
        hold_en = 1'b0;
        do_reset("rst5");
        repeat (8) @(negedge clk);
        check("post_rst_pc0", seen_at(0), 32'h0);
        check("post_rst_pc1", seen_at(1), 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
